// File: rtl/tour_pkg.sv
// Shared definitions for the knight's-tour command sequencer: move
// encodings, command headings and opcodes, response bytes and FSM states.
package tour_pkg;

    localparam int NUM_MOVES = 24;

    // One-hot move encodings as presented by the tour solver
    localparam logic [7:0] MV_0 = 8'h01;   // (-1,+2)
    localparam logic [7:0] MV_1 = 8'h02;   // (+1,+2)
    localparam logic [7:0] MV_2 = 8'h04;   // (-2,+1)
    localparam logic [7:0] MV_3 = 8'h08;   // (-2,-1)
    localparam logic [7:0] MV_4 = 8'h10;   // (-1,-2)
    localparam logic [7:0] MV_5 = 8'h20;   // (+1,-2)
    localparam logic [7:0] MV_6 = 8'h40;   // (+2,-1)
    localparam logic [7:0] MV_7 = 8'h80;   // (+2,+1)

    // Command heading field values
    localparam logic [7:0] HDG_N = 8'h00;
    localparam logic [7:0] HDG_W = 8'h3F;
    localparam logic [7:0] HDG_S = 8'h7F;
    localparam logic [7:0] HDG_E = 8'hBF;

    // Command opcodes
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    // Response bytes returned to the host
    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_POS = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLD_VERT,
        HORZ,
        HOLD_HORZ
    } state_t;

    // Absolute value of a small signed offset, widened to the squares field
    function automatic logic [3:0] magnitude(input logic signed [2:0] v);
        logic [2:0] a;
        a = v[2] ? 3'(-v) : 3'(v);
        return {1'b0, a};
    endfunction

    // Vertical heading: south only for a strictly negative offset
    function automatic logic [7:0] vert_heading(input logic signed [2:0] dy);
        return dy[2] ? HDG_S : HDG_N;
    endfunction

    // Horizontal heading: east only for a strictly positive offset
    function automatic logic [7:0] horz_heading(input logic signed [2:0] dx);
        return (!dx[2] && (dx != 3'sd0)) ? HDG_E : HDG_W;
    endfunction

endpackage

// File: rtl/move_decode.sv
// Turns a one-hot knight move into signed (dx,dy) offsets and the square
// counts of its vertical and horizontal legs. Anything that is not exactly
// one-hot decodes to a null move.
module move_decode
    import tour_pkg::*;
(
    input  logic        [7:0] move,
    output logic signed [2:0] dx,
    output logic signed [2:0] dy,
    output logic        [3:0] vert_sq,
    output logic        [3:0] horz_sq
);

    // Map each one-hot move onto its board offset
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        case (move)
            MV_0: begin dx = -3'sd1; dy =  3'sd2; end
            MV_1: begin dx =  3'sd1; dy =  3'sd2; end
            MV_2: begin dx = -3'sd2; dy =  3'sd1; end
            MV_3: begin dx = -3'sd2; dy = -3'sd1; end
            MV_4: begin dx = -3'sd1; dy = -3'sd2; end
            MV_5: begin dx =  3'sd1; dy = -3'sd2; end
            MV_6: begin dx =  3'sd2; dy = -3'sd1; end
            MV_7: begin dx =  3'sd2; dy =  3'sd1; end
            default: begin dx = 3'sd0; dy = 3'sd0; end
        endcase
    end

    assign vert_sq = magnitude(dy);
    assign horz_sq = magnitude(dx);

endmodule

// File: rtl/tour_cmd_seq.sv
// Sequences a solved knight's tour into vertical/horizontal motion commands
// with a ready/clear/response handshake; outside a tour it simply forwards
// UART commands to the command processor.
module tour_cmd_seq
    import tour_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp
);

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

    state_t             state;
    logic signed [2:0]  dx;
    logic signed [2:0]  dy;
    logic        [3:0]  vert_sq;
    logic        [3:0]  horz_sq;
    logic        [15:0] vert_cmd;
    logic        [15:0] horz_cmd;
    logic               last_move;

    move_decode u_decode (
        .move    (move),
        .dx      (dx),
        .dy      (dy),
        .vert_sq (vert_sq),
        .horz_sq (horz_sq)
    );

    assign vert_cmd  = {OP_MOVE,    vert_heading(dy), vert_sq};
    assign horz_cmd  = {OP_FANFARE, horz_heading(dx), horz_sq};
    assign last_move = (mv_indx == LAST_INDX);

    // Tour state and move index; clr_cmd_rdy wins over send_resp in the
    // ready states simply because send_resp is only looked at in HOLD states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mv_indx <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_tour) begin
                        state   <= VERT;
                        mv_indx <= 5'd0;
                    end
                end
                VERT: begin
                    if (clr_cmd_rdy) state <= HOLD_VERT;
                end
                HOLD_VERT: begin
                    if (send_resp) state <= HORZ;
                end
                HORZ: begin
                    if (clr_cmd_rdy) state <= HOLD_HORZ;
                end
                HOLD_HORZ: begin
                    if (send_resp) begin
                        if (last_move) begin
                            state   <= IDLE;
                            mv_indx <= 5'd0;
                        end else begin
                            state   <= VERT;
                            mv_indx <= mv_indx + 5'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    mv_indx <= 5'd0;
                end
            endcase
        end
    end

    // Output mux: UART passthrough in IDLE, otherwise the current tour leg
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_POS;
        case (state)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_ACK;
            end
            VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b1;
            end
            HOLD_VERT: begin
                cmd     = vert_cmd;
                cmd_rdy = 1'b0;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
            end
            HOLD_HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b0;
                resp    = last_move ? RESP_ACK : RESP_POS;
            end
            default: begin
                cmd     = cmd_UART;
                cmd_rdy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed bench for tour_cmd_seq: UART passthrough, leg pairs, a full
// 24-move tour, handshake timing, collisions, reset and a null move.
module tb_tour_cmd_seq;

    logic        clk;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    // Solver stand-in: either a fixed move or a scripted tour table
    logic        script_mode;
    logic [7:0]  fixed_move;
    logic [7:0]  tour_move [24];

    // Hand-computed legs for each one-hot move bit
    logic [15:0] exp_vert [8];
    logic [15:0] exp_horz [8];

    int checks;
    int failures;

    assign move = script_mode ? ((mv_indx < 5'd24) ? tour_move[mv_indx] : 8'h00)
                              : fixed_move;

    tour_cmd_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .mv_indx          (mv_indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .cmd              (cmd),
        .cmd_rdy          (cmd_rdy),
        .clr_cmd_rdy      (clr_cmd_rdy),
        .send_resp        (send_resp),
        .resp             (resp)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] c, input logic rdy);
        cmd_UART     = c;
        cmd_rdy_UART = rdy;
    endtask

    // Land 2 time units after the active edge, away from it
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // One leg of a tour: wait for ready, check the command, handshake it
    task automatic runLeg(input string tag, input logic [15:0] exp_cmd,
                          input logic [7:0] exp_resp, input int clr_wait,
                          input int resp_wait);
        int n;
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 100) begin
            nextCycle();
            n++;
        end
        checkOutput({tag, " rdy"}, 16'(cmd_rdy), 16'd1);
        checkOutput({tag, " cmd"}, cmd, exp_cmd);
        if (clr_wait > 0) begin
            repeat (clr_wait) nextCycle();
            checkOutput({tag, " rdy held"}, 16'(cmd_rdy), 16'd1);
            checkOutput({tag, " cmd held"}, cmd, exp_cmd);
        end
        clr_cmd_rdy = 1'b1;
        #1;
        checkOutput({tag, " uart clr blocked"}, 16'(clr_cmd_rdy_UART), 16'd0);
        nextCycle();
        clr_cmd_rdy = 1'b0;
        #1;
        checkOutput({tag, " rdy dropped"}, 16'(cmd_rdy), 16'd0);
        checkOutput({tag, " resp"}, 16'(resp), 16'(exp_resp));
        if (resp_wait > 0) begin
            repeat (resp_wait) nextCycle();
            checkOutput({tag, " rdy low in hold"}, 16'(cmd_rdy), 16'd0);
        end
        send_resp = 1'b1;
        nextCycle();
        send_resp = 1'b0;
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start_tour   = 1'b0;
        clr_cmd_rdy  = 1'b0;
        send_resp    = 1'b0;
        script_mode  = 1'b0;
        fixed_move   = 8'h01;
        applyStimulus(16'h0000, 1'b0);

        exp_vert[0] = 16'h2002; exp_horz[0] = 16'h33F1;
        exp_vert[1] = 16'h2002; exp_horz[1] = 16'h3BF1;
        exp_vert[2] = 16'h2001; exp_horz[2] = 16'h33F2;
        exp_vert[3] = 16'h27F1; exp_horz[3] = 16'h33F2;
        exp_vert[4] = 16'h27F2; exp_horz[4] = 16'h33F1;
        exp_vert[5] = 16'h27F2; exp_horz[5] = 16'h3BF1;
        exp_vert[6] = 16'h27F1; exp_horz[6] = 16'h3BF2;
        exp_vert[7] = 16'h2001; exp_horz[7] = 16'h3BF2;
        for (int i = 0; i < 24; i++) tour_move[i] = 8'h01 << (i % 8);

        // Reset state
        #12;
        checkOutput("reset mv_indx", 16'(mv_indx), 16'd0);
        checkOutput("reset cmd_rdy", 16'(cmd_rdy), 16'd0);
        checkOutput("reset resp", 16'(resp), 16'h00A5);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // UART passthrough
        applyStimulus(16'h2003, 1'b1);
        #1;
        checkOutput("uart cmd", cmd, 16'h2003);
        checkOutput("uart rdy", 16'(cmd_rdy), 16'd1);
        checkOutput("uart resp", 16'(resp), 16'h00A5);
        clr_cmd_rdy = 1'b1;
        #1;
        checkOutput("uart clr pass", 16'(clr_cmd_rdy_UART), 16'd1);
        nextCycle();
        clr_cmd_rdy = 1'b0;
        applyStimulus(16'h2003, 1'b0);
        #1;
        checkOutput("uart clr release", 16'(clr_cmd_rdy_UART), 16'd0);
        checkOutput("uart rdy release", 16'(cmd_rdy), 16'd0);

        // Single leg pair then run on to move 7, with a mid-tour start_tour
        fixed_move = 8'h01;
        start_tour = 1'b1;
        nextCycle();
        start_tour = 1'b0;
        #1;
        checkOutput("first rdy latency", 16'(cmd_rdy), 16'd1);
        checkOutput("first mv_indx", 16'(mv_indx), 16'd0);
        runLeg("pair0 vert", 16'h2002, 8'h5A, 0, 0);
        runLeg("pair0 horz", 16'h33F1, 8'h5A, 0, 0);
        checkOutput("pair0 advance", 16'(mv_indx), 16'd1);
        for (int k = 1; k < 7; k++) begin
            runLeg($sformatf("run%0d vert", k), 16'h2002, 8'h5A, 0, 0);
            if (k == 3) begin
                start_tour = 1'b1;
                nextCycle();
                start_tour = 1'b0;
                #1;
                checkOutput("mid start mv_indx", 16'(mv_indx), 16'd3);
                checkOutput("mid start cmd", cmd, 16'h33F1);
                checkOutput("mid start rdy", 16'(cmd_rdy), 16'd1);
            end
            runLeg($sformatf("run%0d horz", k), 16'h33F1, 8'h5A, 0, 0);
        end
        runLeg("run7 vert", 16'h2002, 8'h5A, 0, 0);
        checkOutput("pre-reset mv_indx", 16'(mv_indx), 16'd7);
        checkOutput("pre-reset horz cmd", cmd, 16'h33F1);

        // Asynchronous reset in HORZ at move 7
        applyStimulus(16'h1234, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset mv_indx", 16'(mv_indx), 16'd0);
        checkOutput("mid reset rdy", 16'(cmd_rdy), 16'd1);
        checkOutput("mid reset cmd", cmd, 16'h1234);
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(16'h1234, 1'b0);
        nextCycle();
        checkOutput("after reset rdy", 16'(cmd_rdy), 16'd0);

        // Null move with stretched and colliding handshakes
        fixed_move = 8'h03;
        start_tour = 1'b1;
        nextCycle();
        start_tour = 1'b0;
        #1;
        checkOutput("null vert cmd", cmd, 16'h2000);
        send_resp = 1'b1;
        nextCycle();
        send_resp = 1'b0;
        #1;
        checkOutput("spurious resp rdy", 16'(cmd_rdy), 16'd1);
        checkOutput("spurious resp cmd", cmd, 16'h2000);
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'b1;
        nextCycle();
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        #1;
        checkOutput("collide rdy", 16'(cmd_rdy), 16'd0);
        nextCycle();
        checkOutput("collide still hold", 16'(cmd_rdy), 16'd0);
        checkOutput("collide mv_indx", 16'(mv_indx), 16'd0);
        send_resp = 1'b1;
        nextCycle();
        send_resp = 1'b0;
        #1;
        runLeg("null horz", 16'h33F0, 8'h5A, 10, 50);
        checkOutput("null advance", 16'(mv_indx), 16'd1);
        runLeg("slow vert", 16'h2000, 8'h5A, 10, 50);
        checkOutput("slow no advance", 16'(mv_indx), 16'd1);
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Full scripted tour started alongside a pending UART command
        script_mode = 1'b1;
        applyStimulus(16'h2003, 1'b1);
        start_tour = 1'b1;
        nextCycle();
        start_tour = 1'b0;
        #1;
        checkOutput("tour wins rdy", 16'(cmd_rdy), 16'd1);
        checkOutput("tour wins cmd", cmd, exp_vert[0]);
        checkOutput("tour wins uart clr", 16'(clr_cmd_rdy_UART), 16'd0);
        for (int i = 0; i < 24; i++) begin
            runLeg($sformatf("tour%0d vert", i), exp_vert[i % 8], 8'h5A, 0, 0);
            runLeg($sformatf("tour%0d horz", i), exp_horz[i % 8],
                   (i == 23) ? 8'hA5 : 8'h5A, 0, 0);
        end
        checkOutput("tour end mv_indx", 16'(mv_indx), 16'd0);
        checkOutput("tour end uart rdy", 16'(cmd_rdy), 16'd1);
        checkOutput("tour end uart cmd", cmd, 16'h2003);
        checkOutput("tour end resp", 16'(resp), 16'h00A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
